// File: rtl/aes_pkg.sv
// AES byte-substitution shared definitions: S-box tables, state width, FSM states.
// Tables are stored with entry 0 in the most significant byte.
package aes_pkg;

  localparam int STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb_get(
    input logic [2047:0] t,
    input logic [7:0]    i
  );
    sb_get = t[11'd2047 - {i, 3'b000} -: 8];
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Single-byte AES S-box lookup; inverse by default, forward selectable with
// INV_SUB_BYTES_FWD_EN. Ports: i_byte in, i_fwd (macro only), o_byte out.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic       i_fwd,
`endif
  output logic [7:0] o_byte
);

  always_comb begin
`ifdef INV_SUB_BYTES_FWD_EN
    o_byte = i_fwd ? sb_get(FWD_SBOX, i_byte)
                   : sb_get(INV_SBOX, i_byte);
`else
    o_byte = sb_get(INV_SBOX, i_byte);
`endif
  end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes over a 128-bit state, BYTES_PER_CYCLE lanes.
// Ports: clk, rst (sync high), in_valid/in_ready/data_in, out_valid/out_ready/
// data_out, dir (only with INV_SUB_BYTES_FWD_EN: 1 = forward S-box).
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] data_out
`ifdef INV_SUB_BYTES_FWD_EN
  ,
  input  logic               dir
`endif
);

  localparam int NSTEP = 16 / BYTES_PER_CYCLE;
  localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [STATE_W-1:0] r_in;
  logic [STATE_W-1:0] r_res;
  logic               w_acc;
  logic [7:0]         w_lane_in  [BYTES_PER_CYCLE];
  logic [7:0]         w_lane_out [BYTES_PER_CYCLE];
`ifdef INV_SUB_BYTES_FWD_EN
  logic               r_dir;
`endif

  assign w_acc    = in_valid && in_ready;
  assign data_out = r_res;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = BUSY;
      BUSY:    if (r_cnt == LAST) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Lane l in step c works on byte c*BYTES_PER_CYCLE + l.
  always_comb begin
    for (int l = 0; l < BYTES_PER_CYCLE; l++) w_lane_in[l] = '0;
    for (int k = 0; k < 16; k++) begin
      if (CW'(k / BYTES_PER_CYCLE) == r_cnt)
        w_lane_in[k % BYTES_PER_CYCLE] = r_in[8*(15-k) +: 8];
    end
  end

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    inv_sbox u_sbox (
      .i_byte (w_lane_in[l]),
`ifdef INV_SUB_BYTES_FWD_EN
      .i_fwd  (r_dir),
`endif
      .o_byte (w_lane_out[l])
    );
  end

  // Input is kept apart from the result so data_out only moves in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_in  <= '0;
      r_res <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      r_dir <= 1'b0;
`endif
    end else begin
      if (w_acc) begin
        r_in  <= data_in;
        r_cnt <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
        r_dir <= dir;
`endif
      end
      if (r_state == BUSY) begin
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        for (int k = 0; k < 16; k++) begin
          if (CW'(k / BYTES_PER_CYCLE) == r_cnt)
            r_res[8*(15-k) +: 8] <= w_lane_out[k % BYTES_PER_CYCLE];
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench for inv_sub_bytes_iter: directed vectors, backpressure,
// mid-transaction reset and a BYTES_PER_CYCLE latency sweep.
module tb_inv_sub_bytes_iter;

  localparam logic [127:0] V1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V1_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V2_IN  = 128'h49ded28945db96f17f39871a7702533b;
  localparam logic [127:0] V2_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] ALL00  = 128'h0;
  localparam logic [127:0] ALL52  = {16{8'h52}};
  localparam logic [127:0] ALL63  = {16{8'h63}};
  localparam logic [127:0] ALLFF  = {16{8'hff}};
  localparam logic [127:0] ALL7D  = {16{8'h7d}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
`ifdef INV_SUB_BYTES_FWD_EN
  logic         dir;
`endif

  logic         sw_valid;
  logic [127:0] sw_data;
  logic         sw_ordy;
  logic         sw_rdy [4];
  logic         sw_ov  [4];
  logic [127:0] sw_do  [4];

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef INV_SUB_BYTES_FWD_EN
    ,
    .dir       (dir)
`endif
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int BPC = (g < 2) ? (1 << g) : (1 << (g + 1));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(BPC)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid),
      .in_ready  (sw_rdy[g]),
      .data_in   (sw_data),
      .out_valid (sw_ov[g]),
      .out_ready (sw_ordy),
      .data_out  (sw_do[g])
`ifdef INV_SUB_BYTES_FWD_EN
      ,
      .dir       (1'b0)
`endif
    );
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", data_out, 128'hx);
      end else begin
        chk("sb_data", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("ready_timeout", 128'(n), 128'd0);
  endtask

  task automatic do_txn(input logic [127:0] d, input logic [127:0] e,
                        input logic dr, input int hold);
    int n;
    exp_q.push_back(e);
    wait_ready();
    in_valid = 1'b1;
    data_in  = d;
`ifdef INV_SUB_BYTES_FWD_EN
    dir = dr;
`else
    if (dr) $display("note: dir ignored in this build");
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = ~d;
`ifdef INV_SUB_BYTES_FWD_EN
    dir = ~dr;
`endif
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 128'(n), 128'd4);
    for (int i = 0; i < hold; i++) begin
      chk("hold_data", data_out, e);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
      in_valid = (i == 3);
      data_in  = 128'hdeadbeef;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bubble_out_valid", 128'(out_valid), 128'd0);
    chk("bubble_in_ready", 128'(in_ready), 128'd1);
  endtask

  task automatic reset_abort();
    exp_q.push_back(V1_OUT);
    wait_ready();
    in_valid = 1'b1;
    data_in  = V1_IN;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_data_out", data_out, 128'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_capture", 128'({in_ready, out_valid}), 128'b10);
    end
  endtask

  task automatic sweep();
    int lat [4];
    int want [4];
    want = '{16, 8, 2, 1};
    lat  = '{-1, -1, -1, -1};
    sw_valid = 1'b1;
    sw_data  = V2_IN;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    sw_data  = '1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++)
        if (sw_ov[g] && lat[g] < 0) lat[g] = c;
    end
    for (int g = 0; g < 4; g++) begin
      chk("sweep_latency", 128'(lat[g]), 128'(want[g]));
      chk("sweep_data", sw_do[g], V2_OUT);
    end
    sw_ordy = 1'b1;
    @(posedge clk); #1;
    sw_ordy = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    sw_valid  = 1'b0;
    sw_data   = '0;
    sw_ordy   = 1'b0;
`ifdef INV_SUB_BYTES_FWD_EN
    dir = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_data_out", data_out, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_txn(V1_IN, V1_OUT, 1'b0, 0);
    do_txn(V2_IN, V2_OUT, 1'b0, 10);
    do_txn(ALLFF, ALL7D, 1'b0, 1);
    do_txn(ALL63, ALL00, 1'b0, 0);
    reset_abort();
    do_txn(ALL00, ALL52, 1'b0, 2);
`ifdef INV_SUB_BYTES_FWD_EN
    do_txn(ALL00, ALL63, 1'b1, 0);
    do_txn(ALL63, ALL00, 1'b0, 0);
`endif
    sweep();

    repeat (3) @(posedge clk);
    chk("sb_drain", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_sub_bytes_iter.md
INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

Interface
REQ-001 Parameter BYTES_PER_CYCLE, default 4, number of S-box lanes; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  data_in holds a state to transform.
REQ-005 in_ready  output  1  block can accept a new state.
REQ-006 data_in  input  128  AES state; byte 0 = bits [127:120].
REQ-007 out_valid  output  1  data_out holds the result.
REQ-008 out_ready  input  1  consumer accepts data_out.
REQ-009 data_out  output  128  transformed state, same byte ordering as data_in.
REQ-010 dir  input  1  present only with INV_SUB_BYTES_FWD_EN: 0 = inverse, 1 = forward.

Function
REQ-011 The block SHALL apply the AES inverse S-box independently to each of the 16 bytes; byte i of data_out = InvSbox(byte i of data_in).
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; all other states SHALL drive in_ready 0.
REQ-014 On in_valid && in_ready, the block SHALL capture data_in (and dir) into an internal register, clear the lane counter and enter BUSY.
REQ-015 In BUSY, each cycle the block SHALL substitute BYTES_PER_CYCLE bytes, starting at byte 0 and proceeding in ascending order, writing results into the result register in place.
REQ-016 After 16/BYTES_PER_CYCLE BUSY cycles the block SHALL enter DONE with out_valid = 1; with the default parameter, out_valid rises 4 cycles after the accept edge.
REQ-017 The lane counter SHALL be ceil(log2(16/BYTES_PER_CYCLE)) bits wide (minimum 1) and SHALL wrap to 0 on the last BUSY cycle.
REQ-018 In DONE, data_out and out_valid SHALL hold stable until out_ready = 1.
REQ-019 On out_valid && out_ready, the FSM SHALL return to IDLE and out_valid SHALL fall on the next edge; no new input is accepted in that same cycle (one bubble).
REQ-020 In BUSY and DONE, in_valid SHALL be ignored; data_in changes SHALL have no effect.
REQ-021 data_out SHALL be driven from the result register only; it SHALL NOT change except during BUSY substitution.

Reset
REQ-022 When rst = 1, the next edge SHALL force IDLE, in_ready = 1, out_valid = 0, data_out = 0, lane counter = 0 and the captured dir = 0.
REQ-023 Reset mid-BUSY or mid-DONE SHALL discard the transaction with no partial output valid.
REQ-024 While rst = 1, in_valid SHALL NOT cause a capture.

Configuration
REQ-025 With INV_SUB_BYTES_FWD_EN defined, the dir port SHALL exist; the value captured at accept SHALL select the forward S-box (dir = 1) or the inverse S-box (dir = 0) for the whole transaction.
REQ-026 Without INV_SUB_BYTES_FWD_EN, the dir port SHALL be absent, only inverse S-box logic SHALL be synthesised, and behaviour SHALL equal dir = 0.

Structure
REQ-027 The shared package aes_pkg SHALL hold the inverse and forward S-box tables, the state width constant (128) and the FSM state enum.
REQ-028 One sub-module, inv_sbox (8-bit combinational lookup, with a forward option under the macro), SHALL be instantiated BYTES_PER_CYCLE times.

Verification
REQ-029 Round-trip vector: data_in = d42711aee0bf98f1b8b45de51e415230 -> data_out = 193de3bea0f4e22b9ac68d2ae9f84808, out_valid 4 cycles after accept.
REQ-030 Second vector: data_in = 49ded28945db96f17f39871a7702533b -> a49c7ff2689f352b6b5bea43026a5049; repeat for each legal BYTES_PER_CYCLE (1 -> 16 cycles, 16 -> 1 cycle).
REQ-031 Backpressure: hold out_ready = 0 for 10 cycles in DONE -> data_out stable, in_ready = 0, a new in_valid pulse is ignored.
REQ-032 Reset during BUSY cycle 2 -> next edge in IDLE, out_valid = 0, data_out = 0; the following transaction of all-zero input -> 52 repeated in all 16 bytes.
REQ-033 With INV_SUB_BYTES_FWD_EN: dir = 1, data_in = ac73cf7befc111df13b5d6b545235ab8 -> 91... forward result; dir = 1 with input all 00 -> all 63; dir = 0 with input all 63 -> all 00.
